key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter N_KEYS, default 2, meaning number of independent push-button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning stable-sample count (20 ms at 50 MHz); legal range 2 or more.
REQ-003 SHALL have parameter LONG_CYCLES, default 50_000_000, meaning held-time for a long press (1 s at 50 MHz); SHALL be greater than DEBOUNCE_CYCLES.
REQ-004 clk  input  1  system clock, 50 MHz board clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 key_n  input  N_KEYS  raw asynchronous board keys, active-low (0 = pressed).
REQ-007 key_level  output  N_KEYS  debounced key state, active-high (1 = pressed).
REQ-008 press_pulse  output  N_KEYS  one-cycle strobe per validated press.
REQ-009 release_pulse  output  N_KEYS  one-cycle strobe per validated release.
REQ-010 long_pulse  output  N_KEYS  one-cycle strobe when a press has been held LONG_CYCLES.

Function
REQ-011 Each key_n bit SHALL pass through a 2-flop synchronizer; the second flop output is key_s.
REQ-012 Each channel SHALL run a 4-state FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 RELEASED: key_s=0 -> PRESS_WAIT with deb_cnt cleared; otherwise stay.
REQ-014 PRESS_WAIT: key_s=1 -> RELEASED with deb_cnt cleared; deb_cnt=DEBOUNCE_CYCLES-1 -> PRESSED, hold_cnt cleared, press_pulse set; otherwise deb_cnt increments.
REQ-015 PRESSED: key_s=1 -> RELEASE_WAIT with deb_cnt cleared; otherwise stay.
REQ-016 RELEASE_WAIT: key_s=0 -> PRESSED without clearing hold_cnt; deb_cnt=DEBOUNCE_CYCLES-1 -> RELEASED, release_pulse set; otherwise deb_cnt increments.
REQ-017 hold_cnt SHALL increment in PRESSED and RELEASE_WAIT and saturate at LONG_CYCLES-1; long_pulse SHALL be set on the single cycle hold_cnt reaches LONG_CYCLES-1, at most once per press.
REQ-018 key_level SHALL be 1 in PRESSED and RELEASE_WAIT, and 0 in RELEASED and PRESS_WAIT.
REQ-019 All outputs SHALL be registered; each pulse SHALL be high for exactly one clk cycle.
REQ-020 Latency: for a stable press whose first low sample is rising edge 0, press_pulse SHALL be high in the cycle following edge DEBOUNCE_CYCLES+2. Release latency SHALL be identical.
REQ-021 A bounce shorter than DEBOUNCE_CYCLES consecutive key_s samples SHALL produce no pulse and no key_level change.
REQ-022 deb_cnt SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and hold_cnt $clog2(LONG_CYCLES) bits wide; neither counter SHALL wrap.
REQ-023 Channels SHALL be fully independent; simultaneous events on several keys SHALL each produce their own pulses in the same cycle.
REQ-024 press_pulse and release_pulse SHALL never both be high on one channel in the same cycle.

Reset
REQ-025 Asserting rst SHALL immediately set: synchronizer flops to 1; FSM to RELEASED; deb_cnt and hold_cnt to 0; key_level, press_pulse, release_pulse and long_pulse to 0.
REQ-026 A reset asserted mid-debounce or mid-press SHALL discard that event; a key still held after rst deasserts SHALL be re-validated from RELEASED, and the full latency of REQ-020 applies.

Structure
REQ-027 The state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT) SHALL be a typedef in the shared package key_pkg, together with default constants DEB_CYCLES_50M and LONG_CYCLES_50M.
REQ-028 One sub-module, debounce_channel (synchronizer, FSM and counters for one key), SHALL be instantiated N_KEYS times by a generate loop in key_debouncer.

Verification
Run the bench at a 20 ns clk period with DEBOUNCE_CYCLES=4 and LONG_CYCLES=16.
REQ-029 Clean press: key_n[0]=0 held 30 cycles -> press_pulse[0] high one cycle after edge 6; key_level[0]=1 from then on.
REQ-030 Glitch: key_n[0] low for 3 cycles then high -> no pulses and key_level[0] stays 0.
REQ-031 Long press: key_n[0] low for 40 cycles -> exactly one long_pulse[0], 15 cycles after press_pulse[0]. Release then gives one release_pulse[0] 6 cycles after key_n[0] rises.
REQ-032 Release bounce: in PRESSED, key_n[0] high for 2 cycles then low -> no release_pulse, and key_level[0] stays 1.
REQ-033 Reset mid-operation: rst pulsed for 128 ns while in PRESS_WAIT, key still low -> all outputs 0 during reset; press_pulse appears 6 cycles after the first low sample following rst deassert.
REQ-034 Simultaneous keys: key_n=2'b00 at the same edge -> press_pulse=2'b11 in the same cycle.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and board-rate defaults for the push-button debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_e;

  // 20 ms debounce and 1 s long-press at a 50 MHz board clock.
  localparam int unsigned DEB_CYCLES_50M  = 1_000_000;
  localparam int unsigned LONG_CYCLES_50M = 50_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One key: 2-flop synchronizer, debounce FSM, hold-time counter and registered strobes.
module debounce_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_50M,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_50M
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 2);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          key_s;
  key_state_e    state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  assign key_s = sync2_q;

  always_comb begin
    sync1_d    = key_n;
    sync2_d    = sync1_q;
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;

    // Hold time keeps running through RELEASE_WAIT so a release bounce does not restart it.
    if ((state_q == PRESSED || state_q == RELEASE_WAIT) && hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      long_d     = (hold_cnt_q == HOLD_PRE);
    end

    unique case (state_q)
      RELEASED: begin
        if (!key_s) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d   = RELEASED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_MAX) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
          press_d    = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = PRESSED;
        end else if (deb_cnt_q == DEB_MAX) begin
          state_d   = RELEASED;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase

    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= RELEASED;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: rtl/key_debouncer.sv
// Multi-key debouncer: one independent debounce_channel per active-low board key.
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_50M,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_50M
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .key_n        (key_n[i]),
      .key_level    (key_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed self-checking bench for key_debouncer with short debounce/long-press windows.
module tb_key_debouncer;

  localparam int unsigned NK   = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;
  logic [NK-1:0] long_pulse;

  key_debouncer #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_n        (key_n),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c0       = 0;
  int overlap  = 0;
  int press_both;
  int press_cnt[NK], release_cnt[NK], long_cnt[NK];
  int press_at[NK], release_at[NK], long_at[NK], level_rise_at[NK];
  int level_hi_seen[NK], level_lo_seen[NK];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Positions are counted in ticks: tick k observes outputs just after the (k-1)th edge
  // following the stimulus change, so a pulse "after edge 6" lands on tick 7.
  task automatic clear_stats();
    c0 = cyc;
    press_both = 0;
    for (int ch = 0; ch < NK; ch++) begin
      press_cnt[ch]     = 0;
      release_cnt[ch]   = 0;
      long_cnt[ch]      = 0;
      press_at[ch]      = -1;
      release_at[ch]    = -1;
      long_at[ch]       = -1;
      level_rise_at[ch] = -1;
      level_hi_seen[ch] = 0;
      level_lo_seen[ch] = 0;
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int ch = 0; ch < NK; ch++) begin
        if (press_pulse[ch])   begin press_cnt[ch]++;   press_at[ch]   = cyc - c0; end
        if (release_pulse[ch]) begin release_cnt[ch]++; release_at[ch] = cyc - c0; end
        if (long_pulse[ch])    begin long_cnt[ch]++;    long_at[ch]    = cyc - c0; end
        if (key_level[ch]) begin
          level_hi_seen[ch]++;
          if (level_rise_at[ch] < 0) level_rise_at[ch] = cyc - c0;
        end else begin
          level_lo_seen[ch]++;
        end
        if (press_pulse[ch] && release_pulse[ch]) overlap++;
      end
      if (press_pulse == 2'b11) press_both++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    key_n = '1;
    #5;
    check_eq("reset_level",   int'(key_level),     0);
    check_eq("reset_press",   int'(press_pulse),   0);
    check_eq("reset_release", int'(release_pulse), 0);
    check_eq("reset_long",    int'(long_pulse),    0);
    #30;
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    step(3);
    check_eq("idle_level", level_hi_seen[0] + level_hi_seen[1], 0);
    check_eq("idle_press", press_cnt[0] + press_cnt[1], 0);

    // Clean long press on key 0
    clear_stats();
    key_n[0] = 1'b0;
    step(40);
    check_eq("lp_press_cnt",   press_cnt[0],     1);
    check_eq("lp_press_at",    press_at[0],      7);
    check_eq("lp_level_rise",  level_rise_at[0], 7);
    check_eq("lp_level_held",  level_hi_seen[0], 34);
    check_eq("lp_long_cnt",    long_cnt[0],      1);
    check_eq("lp_long_at",     long_at[0],       22);
    check_eq("lp_release_cnt", release_cnt[0],   0);
    check_eq("lp_ch1_idle",    press_cnt[1] + level_hi_seen[1], 0);

    clear_stats();
    key_n[0] = 1'b1;
    step(12);
    check_eq("rel_cnt",      release_cnt[0], 1);
    check_eq("rel_at",       release_at[0],  7);
    check_eq("rel_level",    int'(key_level[0]), 0);
    check_eq("rel_no_press", press_cnt[0] + long_cnt[0], 0);

    // Press glitch of 3 cycles
    clear_stats();
    key_n[0] = 1'b0;
    step(3);
    key_n[0] = 1'b1;
    step(15);
    check_eq("gl_press",   press_cnt[0],     0);
    check_eq("gl_release", release_cnt[0],   0);
    check_eq("gl_long",    long_cnt[0],      0);
    check_eq("gl_level",   level_hi_seen[0], 0);

    // Release bounce of 2 cycles while pressed
    clear_stats();
    key_n[0] = 1'b0;
    step(10);
    check_eq("rb_press_at", press_at[0], 7);
    clear_stats();
    key_n[0] = 1'b1;
    step(2);
    key_n[0] = 1'b0;
    step(20);
    check_eq("rb_release",  release_cnt[0],   0);
    check_eq("rb_level_lo", level_lo_seen[0], 0);
    check_eq("rb_repress",  press_cnt[0],     0);
    check_eq("rb_long_at",  long_at[0],       12);
    clear_stats();
    key_n[0] = 1'b1;
    step(12);
    check_eq("rb_final_release", release_cnt[0], 1);

    // Reset while in PRESS_WAIT, key still held
    clear_stats();
    key_n[0] = 1'b0;
    step(3);
    #5;
    rst = 1'b1;
    #1;
    check_eq("mr_level",   int'(key_level),     0);
    check_eq("mr_press",   int'(press_pulse),   0);
    check_eq("mr_release", int'(release_pulse), 0);
    check_eq("mr_long",    int'(long_pulse),    0);
    #127;
    rst = 1'b0;
    clear_stats();
    step(10);
    check_eq("mr_press_cnt", press_cnt[0], 1);
    check_eq("mr_press_at",  press_at[0],  7);
    clear_stats();
    key_n[0] = 1'b1;
    step(12);
    check_eq("mr_release_cnt", release_cnt[0], 1);

    // Both keys pressed at the same edge
    clear_stats();
    key_n = 2'b00;
    step(10);
    check_eq("sim_both",     press_both,       1);
    check_eq("sim_at0",      press_at[0],      7);
    check_eq("sim_at1",      press_at[1],      7);
    check_eq("sim_level",    int'(key_level),  3);
    clear_stats();
    key_n = 2'b11;
    step(12);
    check_eq("sim_rel0",     release_at[0],    7);
    check_eq("sim_rel1",     release_at[1],    7);
    check_eq("sim_rel_cnt",  release_cnt[0] + release_cnt[1], 2);

    check_eq("no_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
